// File: rtl/fe_fetch_sequencer.sv
// rtl/fe_fetch_sequencer.sv - RV32I front-end fetch sequencer: PC, imem request/response, decode handoff
// Wrong-path responses are squashed after a redirect; a misaligned redirect halts fetch until reset.
module fe_fetch_sequencer #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus_4,
  input  logic            instr_ready,
  output logic            fetch_misaligned
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;

  state_t          state;
  logic            squash;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  logic            redir_ok;
  logic            redir_bad;

  assign imem_req_addr = pc;
  assign pc_next_seq   = pc + XLEN'(4);

  // Redirects are dead once halted; only reset leaves HALT.
  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00) && (state != HALT);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state != HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= REQ;
      pc               <= RESET_PC;
      squash           <= 1'b0;
      imem_req_valid   <= 1'b1;
      instr_valid      <= 1'b0;
      instr            <= '0;
      instr_pc         <= '0;
      instr_pc_plus_4  <= '0;
      fetch_misaligned <= 1'b0;
    end else if (redir_bad) begin
      state            <= HALT;
      squash           <= 1'b0;
      imem_req_valid   <= 1'b0;
      instr_valid      <= 1'b0;
      fetch_misaligned <= 1'b1;
    end else begin
      case (state)
        REQ: begin
          if (redir_ok) pc <= redirect_pc;
          if (imem_req_ready) begin
            // Memory took the old address; its response must be thrown away.
            state          <= WAIT;
            imem_req_valid <= 1'b0;
            squash         <= redir_ok;
          end
        end
        WAIT: begin
          if (redir_ok) begin
            pc <= redirect_pc;
            if (imem_rsp_valid) begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
              squash         <= 1'b0;
            end else begin
              squash <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (squash) begin
              squash         <= 1'b0;
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else begin
              instr           <= imem_rsp_data;
              instr_pc        <= pc;
              instr_pc_plus_4 <= pc_next_seq;
              pc              <= pc_next_seq;
              instr_valid     <= 1'b1;
              state           <= HOLD;
            end
          end
        end
        HOLD: begin
          // A redirect wins over a same-cycle consume: the held word is wrong-path.
          if (redir_ok || instr_ready) begin
            if (redir_ok) pc <= redirect_pc;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b1;
            state          <= REQ;
          end
        end
        default: begin
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fe_fetch_sequencer.sv
// tb/tb_fe_fetch_sequencer.sv - directed vector bench for fe_fetch_sequencer
module tb_fe_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus_4;
  logic        instr_ready;
  logic        fetch_misaligned;

  fe_fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus_4 (instr_pc_plus_4),
    .instr_ready     (instr_ready),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rspv;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        ir;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic        e_mis;
    logic        ci;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic rdy, input logic rspv, input logic [31:0] data,
                     input logic rv, input logic [31:0] rpc, input logic ir,
                     input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_instr, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                     input logic e_mis, input logic ci);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rspv = rspv; v.data = data; v.rv = rv; v.rpc = rpc; v.ir = ir;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_pc4 = e_pc4; v.e_mis = e_mis; v.ci = ci;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rspv, input logic [31:0] data,
                       input logic rv, input logic [31:0] rpc, input logic ir);
    rst = r; imem_req_ready = rdy; imem_rsp_valid = rspv; imem_rsp_data = data;
    redirect_valid = rv; redirect_pc = rpc; instr_ready = ir;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].rspv, tbl[i].data, tbl[i].rv, tbl[i].rpc, tbl[i].ir);
      chk("imem_req_valid", i, {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rv});
      chk("imem_req_addr", i, imem_req_addr, tbl[i].e_addr);
      chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, tbl[i].e_iv});
      chk("fetch_misaligned", i, {31'd0, fetch_misaligned}, {31'd0, tbl[i].e_mis});
      if (tbl[i].ci) begin
        chk("instr", i, instr, tbl[i].e_instr);
        chk("instr_pc", i, instr_pc, tbl[i].e_pc);
        chk("instr_pc_plus_4", i, instr_pc_plus_4, tbl[i].e_pc4);
      end
    end
  endtask

  localparam logic [31:0] RP = 32'h0040_0000;

  int split;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    //   rst rdy rsp data          rv rpc           ir  e_rv e_addr        iv instr         pc            pc4           mis ci
    // Zero-wait streaming.
    add(1, 0, 0, 32'h0,         0, 32'h0,        0,  1, RP,            0, 32'h0,        32'h0,        32'h0,        0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, RP,            0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 1, 32'hAAAA0001,  0, 32'h0,        0,  0, 32'h00400004,  1, 32'hAAAA0001, RP,           32'h00400004, 0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1,  1, 32'h00400004,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1,  0, 32'h00400004,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 1, 32'hAAAA0002,  0, 32'h0,        0,  0, 32'h00400008,  1, 32'hAAAA0002, 32'h00400004, 32'h00400008, 0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1,  1, 32'h00400008,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1,  0, 32'h00400008,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 1, 32'hAAAA0003,  0, 32'h0,        0,  0, 32'h0040000C,  1, 32'hAAAA0003, 32'h00400008, 32'h0040000C, 0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1,  1, 32'h0040000C,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    // Request and decode backpressure after a fresh reset.
    add(1, 0, 0, 32'h0,         0, 32'h0,        0,  1, RP,            0, 32'h0,        32'h0,        32'h0,        0, 1);
    add(0, 0, 0, 32'h0,         0, 32'h0,        0,  1, RP,            0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        0,  1, RP,            0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        0,  1, RP,            0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, RP,            0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, RP,            0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 1, 32'hBBBB0001,  0, 32'h0,        0,  0, 32'h00400004,  1, 32'hBBBB0001, RP,           32'h00400004, 0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400004,  1, 32'hBBBB0001, RP,           32'h00400004, 0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400004,  1, 32'hBBBB0001, RP,           32'h00400004, 0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400004,  1, 32'hBBBB0001, RP,           32'h00400004, 0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400004,  1, 32'hBBBB0001, RP,           32'h00400004, 0, 1);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h00400004,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    // Redirect during a 4-cycle WAIT squashes the in-flight response.
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400004,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,         1, 32'h00400100, 0,  0, 32'h00400100,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400100,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400100,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'hDEAD0000,  0, 32'h0,        0,  1, 32'h00400100,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400100,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'hCCCC0001,  0, 32'h0,        0,  0, 32'h00400104,  1, 32'hCCCC0001, 32'h00400100, 32'h00400104, 0, 1);
    // Redirect in HOLD coinciding with instr_ready.
    add(0, 0, 0, 32'h0,         1, 32'h00400200, 1,  1, 32'h00400200,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400200,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'hEEEE0001,  0, 32'h0,        0,  0, 32'h00400204,  1, 32'hEEEE0001, 32'h00400200, 32'h00400204, 0, 1);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h00400204,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    // PC wrap at the top of the address space.
    add(0, 0, 0, 32'h0,         1, 32'hFFFFFFFC, 0,  1, 32'hFFFFFFFC,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'hFFFFFFFC,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h12345678,  0, 32'h0,        0,  0, 32'h00000000,  1, 32'h12345678, 32'hFFFFFFFC, 32'h00000000, 0, 1);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h00000000,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    // Misaligned redirect halts; pc is left alone.
    add(0, 0, 0, 32'h0,         1, 32'h00400102, 0,  0, 32'h00000000,  0, 32'h0,        32'h0,        32'h0,        1, 0);
    split = tbl.size();
    // Reset clears the halt, then same-cycle redirect corner cases.
    add(1, 0, 0, 32'h0,         0, 32'h0,        0,  1, RP,            0, 32'h0,        32'h0,        32'h0,        0, 1);
    add(0, 1, 0, 32'h0,         1, 32'h00400300, 0,  0, 32'h00400300,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'hDEAD0001,  0, 32'h0,        0,  1, 32'h00400300,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400300,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h11110001,  0, 32'h0,        0,  0, 32'h00400304,  1, 32'h11110001, 32'h00400300, 32'h00400304, 0, 1);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h00400304,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400304,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'hDEAD0002,  1, 32'h00400400, 0,  1, 32'h00400400,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h00400400,  0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h22220001,  0, 32'h0,        0,  0, 32'h00400404,  1, 32'h22220001, 32'h00400400, 32'h00400404, 0, 1);
    // Reset mid-HOLD, then a stale response lands in REQ and is ignored.
    add(1, 0, 0, 32'h0,         0, 32'h0,        0,  1, RP,            0, 32'h0,        32'h0,        32'h0,        0, 1);
    add(0, 0, 1, 32'hDEAD0003,  0, 32'h0,        0,  1, RP,            0, 32'h0,        32'h0,        32'h0,        0, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,        0,  0, RP,            0, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h33330001,  0, 32'h0,        0,  0, 32'h00400004,  1, 32'h33330001, RP,           32'h00400004, 0, 1);

    run_rows(0, split - 1);

    // HALT holds for 20 cycles against ready memory, responses and aligned redirects.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, i[0], 32'hF00D0000 + i, 1'b1, RP, 1'b1);
      chk("halt_req_valid", i, {31'd0, imem_req_valid}, 32'd0);
      chk("halt_instr_valid", i, {31'd0, instr_valid}, 32'd0);
      chk("halt_misaligned", i, {31'd0, fetch_misaligned}, 32'd1);
      chk("halt_addr", i, imem_req_addr, 32'h00000000);
    end

    run_rows(split, tbl.size() - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fe_fetch_sequencer.md
# fe_fetch_sequencer

Front-end fetch controller for the RV32I core. Owns the architectural PC register, issues instruction-memory reads over a valid/ready request channel, captures the response, and presents one instruction at a time to decode with a valid/ready handshake. Accepts redirects (taken branch, JAL, JALR target) from execute, squashes wrong-path fetches, and halts on a misaligned target.

## Interface
- RESET_PC, 32'h0040_0000, PC loaded on reset
- XLEN, 32, address/data width; only 32 supported
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  read request pending
- imem_req_addr  out  XLEN  word address requested; sampled by memory only on valid&ready
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  read data valid, one pulse per accepted request, ≥1 cycle after acceptance
- imem_rsp_data  in  XLEN  instruction word
- redirect_valid  in  1  execute requests PC change
- redirect_pc  in  XLEN  new PC (ALU result for B/J/JALR)
- instr_valid  out  1  instruction held for decode
- instr  out  XLEN  instruction word
- instr_pc  out  XLEN  PC of instr
- instr_pc_plus_4  out  XLEN  instr_pc + 4, mod 2^32
- instr_ready  in  1  decode consumes instr
- fetch_misaligned  out  1  sticky halt flag

## Operation
- States: REQ, WAIT, HOLD, HALT. Reset enters REQ, pc <= RESET_PC.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready go WAIT. imem_rsp_valid ignored in REQ.
- WAIT: imem_req_valid=0. On imem_rsp_valid with squash=0: instr <= imem_rsp_data, instr_pc <= pc, instr_pc_plus_4 <= pc+4, pc <= pc+4, go HOLD. With squash=1: discard data, clear squash, go REQ.
- HOLD: instr_valid=1, outputs stable. On instr_ready go REQ.
- Redirect (redirect_valid=1, redirect_pc[1:0]==0) has priority over every other event in the same cycle; pc <= redirect_pc:
  - REQ, not accepted this cycle: stay REQ; address updates next cycle.
  - REQ, accepted same cycle: go WAIT, squash <= 1.
  - WAIT, no response this cycle: stay WAIT, squash <= 1.
  - WAIT, response same cycle: discard response, go REQ.
  - HOLD: instr_valid drops next cycle, go REQ; a same-cycle instr_valid&instr_ready is not a transfer (held instruction is wrong-path).
- Redirect with redirect_pc[1:0]!=0: go HALT from any state, fetch_misaligned <= 1, pc unchanged. HALT: no requests, instr_valid=0, responses ignored; only rst exits.
- Redirect while in HALT ignored.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000, no flag.

## Timing
- Reset values: imem_req_valid=0 during rst cycle and 1 from first post-reset cycle; imem_req_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=0; instr_pc_plus_4=0; fetch_misaligned=0; squash=0.
- Reset mid-operation: state, squash, halt flag cleared; a response to a pre-reset request arrives in REQ and is ignored (memory must not return it after the next acceptance).
- Latency: request accepted cycle t, response cycle t+k (k≥1), instr_valid from t+k+1. Consumed at cycle h -> next imem_req_valid at h+1. Zero-wait memory (ready=1, k=1): one instruction per 3 cycles.
- Redirect at cycle r -> imem_req_addr=redirect_pc no later than r+1 (REQ/HOLD/WAIT-with-response) or the cycle after the squashed response.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset then ready=1, k=1, instr_ready=1: addrs 0x00400000, 0x00400004, 0x00400008; instr_pc_plus_4 of first = 0x00400004; instr_valid every third cycle.
- Backpressure: imem_req_ready low 3 cycles then high -> imem_req_addr held 0x00400000 throughout, single acceptance; instr_ready low 4 cycles -> instr/instr_pc stable, no new request.
- Redirect to 0x00400100 while WAIT with k=4 -> response discarded (instr_valid stays 0), next request addr 0x00400100, delivered instr_pc=0x00400100.
- Redirect in HOLD coinciding with instr_ready=1 -> instr_valid 0 next cycle, next addr=redirect_pc, no pc+4 fetch issued.
- Redirect to 0x00400102 -> fetch_misaligned=1, imem_req_valid stays 0 for 20 cycles; rst pulse clears flag, fetch restarts at 0x00400000.
- pc=0xFFFFFFFC via redirect -> instr_pc_plus_4=0x00000000, next request addr 0x00000000.
